// File: rtl/swap_datapath.sv
// swap_datapath: three-register datapath driven by the register-swap controller.
// A shared bus carries one register selected by H1..H3; C1..C3 capture the bus.
// A passive checker tracks the T1 -> T2 -> T3 swap sequence, counts completed
// swaps and flags illegal strobe combinations. An external port presets the
// registers while no strobe is active.
//
// Output signalling: valid is a one-cycle pulse with no ready/back-pressure.
// It is high for exactly the cycle after the edge that sampled a legal T3 that
// closed a swap. swap_cnt is already updated in that same cycle. ld_rej is
// likewise a one-cycle pulse following a rejected ext_ld.
module swap_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             H1,
    input  logic             H2,
    input  logic             H3,
    input  logic             C1,
    input  logic             C2,
    input  logic             C3,
    input  logic             Done,
    input  logic             ext_ld,
    input  logic [1:0]       ext_sel,
    input  logic [WIDTH-1:0] ext_data,
    output logic [WIDTH-1:0] R1_q,
    output logic [WIDTH-1:0] R2_q,
    output logic [WIDTH-1:0] R3_q,
    output logic [WIDTH-1:0] bus,
    output logic             conflict,
    output logic             order_err,
    output logic             ld_rej,
    output logic [7:0]       swap_cnt,
    output logic             valid,
    output logic [1:0]       chk_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_P1   = 2'd1,
        S_P2   = 2'd2
    } chk_state_e;

    typedef enum logic [2:0] {
        CL_NONE = 3'd0,
        CL_T1   = 3'd1,
        CL_T2   = 3'd2,
        CL_T3   = 3'd3,
        CL_ILL  = 3'd4
    } strobe_class_e;

    // Strobe vector ordered {H1,H2,H3,C1,C2,C3,Done}.
    localparam logic [6:0] PAT_T1 = 7'b0100010;  // H2 & C3
    localparam logic [6:0] PAT_T2 = 7'b1000100;  // H1 & C2
    localparam logic [6:0] PAT_T3 = 7'b0011001;  // H3 & C1 & Done

    chk_state_e      state_q, state_d;
    strobe_class_e   cls;
    logic [6:0]      strobes;
    logic [1:0]      h_cnt;
    logic            one_h;
    logic            multi_h;
    logic            any_strobe;
    logic            load_ok;
    logic            swap_done;
    logic            seq_err;

    logic [WIDTH-1:0] r1_d, r2_d, r3_d;
    logic             conflict_q, order_err_q, ld_rej_q, valid_q;
    logic [7:0]       swap_cnt_q;

    assign strobes    = {H1, H2, H3, C1, C2, C3, Done};
    assign h_cnt      = {1'b0, H1} + {1'b0, H2} + {1'b0, H3};
    assign one_h      = (h_cnt == 2'd1);
    assign multi_h    = (h_cnt > 2'd1);
    assign any_strobe = |strobes;
    assign load_ok    = ext_ld && !any_strobe && (ext_sel != 2'b00);

    // Shared bus: only a single driver puts a register on it, otherwise zero.
    always_comb begin
        bus = '0;
        if (one_h) begin
            if (H1)      bus = R1_q;
            else if (H2) bus = R2_q;
            else         bus = R3_q;
        end
    end

    // Register next-state: bus capture under a single driver, or external preset.
    // A register driving and capturing at once reloads its own value.
    always_comb begin
        r1_d = R1_q;
        r2_d = R2_q;
        r3_d = R3_q;
        if (one_h) begin
            if (C1) r1_d = bus;
            if (C2) r2_d = bus;
            if (C3) r3_d = bus;
        end
        if (load_ok) begin
            case (ext_sel)
                2'b01:   r1_d = ext_data;
                2'b10:   r2_d = ext_data;
                2'b11:   r3_d = ext_data;
                default: ;
            endcase
        end
    end

    // Classify the strobes sampled at this edge.
    always_comb begin
        cls = CL_ILL;
        if (!any_strobe)             cls = CL_NONE;
        else if (strobes == PAT_T1)  cls = CL_T1;
        else if (strobes == PAT_T2)  cls = CL_T2;
        else if (strobes == PAT_T3)  cls = CL_T3;
    end

    // Checker next-state: advance on the expected step, hold on idle, else error.
    always_comb begin
        state_d   = state_q;
        swap_done = 1'b0;
        seq_err   = 1'b0;
        if (cls != CL_NONE) begin
            state_d = S_IDLE;
            seq_err = 1'b1;
            case (state_q)
                S_IDLE: if (cls == CL_T1) begin state_d = S_P1; seq_err = 1'b0; end
                S_P1:   if (cls == CL_T2) begin state_d = S_P2; seq_err = 1'b0; end
                S_P2:   if (cls == CL_T3) begin
                            state_d   = S_IDLE;
                            seq_err   = 1'b0;
                            swap_done = 1'b1;
                        end
                default: ;
            endcase
        end
    end

    // State and status registers; reset takes priority over every strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            R1_q        <= '0;
            R2_q        <= '0;
            R3_q        <= '0;
            state_q     <= S_IDLE;
            conflict_q  <= 1'b0;
            order_err_q <= 1'b0;
            ld_rej_q    <= 1'b0;
            valid_q     <= 1'b0;
            swap_cnt_q  <= 8'd0;
        end else begin
            R1_q        <= r1_d;
            R2_q        <= r2_d;
            R3_q        <= r3_d;
            state_q     <= state_d;
            conflict_q  <= conflict_q | multi_h;
            order_err_q <= order_err_q | seq_err;
            ld_rej_q    <= ext_ld & any_strobe;
            valid_q     <= swap_done;
            if (swap_done) swap_cnt_q <= swap_cnt_q + 8'd1;
        end
    end

    assign conflict    = conflict_q;
    assign order_err   = order_err_q;
    assign ld_rej      = ld_rej_q;
    assign valid       = valid_q;
    assign swap_cnt    = swap_cnt_q;
    assign chk_state_o = state_q;

endmodule

// File: tb/tb_swap_datapath.sv
// Directed bench for swap_datapath: a table of per-edge vectors with
// hand-computed expectations, then sequences for reset mid-swap and the
// 256-swap counter wrap.
module tb_swap_datapath;

  typedef struct {
    logic       rst_n;
    logic [2:0] h;      // {H1,H2,H3}
    logic [2:0] c;      // {C1,C2,C3}
    logic       done;
    logic       ld;
    logic [1:0] sel;
    logic [7:0] data;
    logic [7:0] e_bus;
    logic [7:0] e_r1;
    logic [7:0] e_r2;
    logic [7:0] e_r3;
    logic       e_conf;
    logic       e_oerr;
    logic       e_rej;
    logic       e_valid;
    logic [7:0] e_cnt;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       H1, H2, H3, C1, C2, C3, Done, ext_ld;
  logic [1:0] ext_sel;
  logic [7:0] ext_data;
  logic [7:0] R1_q, R2_q, R3_q, bus, swap_cnt;
  logic       conflict, order_err, ld_rej, valid;
  logic [1:0] chk_state_o;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] bus_seen;
  logic [7:0] exp_q[$];
  vec_t       vecs[$];

  swap_datapath #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .H1(H1), .H2(H2), .H3(H3), .C1(C1), .C2(C2), .C3(C3), .Done(Done),
    .ext_ld(ext_ld), .ext_sel(ext_sel), .ext_data(ext_data),
    .R1_q(R1_q), .R2_q(R2_q), .R3_q(R3_q), .bus(bus),
    .conflict(conflict), .order_err(order_err), .ld_rej(ld_rej),
    .swap_cnt(swap_cnt), .valid(valid), .chk_state_o(chk_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one edge's worth of inputs at the falling edge, snapshot the bus,
  // then return 1 ns after the rising edge that samples them.
  task automatic drive(input logic rst_n, input logic [2:0] h, input logic [2:0] c,
                       input logic done, input logic ld, input logic [1:0] sel,
                       input logic [7:0] data);
    @(negedge clk);
    reset = rst_n;
    {H1, H2, H3} = h;
    {C1, C2, C3} = c;
    Done = done; ext_ld = ld; ext_sel = sel; ext_data = data;
    #1;
    bus_seen = bus;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00, 8'h00);
  endtask

  function automatic vec_t mk(input logic rst_n, input logic [2:0] h, input logic [2:0] c,
                              input logic done, input logic ld, input logic [1:0] sel,
                              input logic [7:0] data, input logic [7:0] e_bus,
                              input logic [7:0] e_r1, input logic [7:0] e_r2,
                              input logic [7:0] e_r3, input logic e_conf,
                              input logic e_oerr, input logic e_rej,
                              input logic e_valid, input logic [7:0] e_cnt);
    vec_t v;
    v.rst_n = rst_n; v.h = h; v.c = c; v.done = done; v.ld = ld; v.sel = sel;
    v.data = data; v.e_bus = e_bus; v.e_r1 = e_r1; v.e_r2 = e_r2; v.e_r3 = e_r3;
    v.e_conf = e_conf; v.e_oerr = e_oerr; v.e_rej = e_rej; v.e_valid = e_valid;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check_outputs(input string tag, input logic [7:0] r1, input logic [7:0] r2,
                               input logic [7:0] r3, input logic cf, input logic oe,
                               input logic rj, input logic vl, input logic [7:0] cnt);
    chk({tag, " R1"}, R1_q, r1);
    chk({tag, " R2"}, R2_q, r2);
    chk({tag, " R3"}, R3_q, r3);
    chk({tag, " conflict"}, conflict, cf);
    chk({tag, " order_err"}, order_err, oe);
    chk({tag, " ld_rej"}, ld_rej, rj);
    chk({tag, " valid"}, valid, vl);
    chk({tag, " swap_cnt"}, swap_cnt, cnt);
  endtask

  initial begin
    int n_valid;
    vec_t v;
    string tag;

    reset = 1'b0;
    {H1, H2, H3, C1, C2, C3, Done, ext_ld} = '0;
    ext_sel = 2'b00; ext_data = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_outputs("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    //                  rst  H       C       D     ld    sel    data   | bus    R1     R2     R3    cf    oe    rj    vl    cnt
    // Preset, then one full legal swap of R1/R2 via R3.
    vecs.push_back(mk(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 2'b01, 8'hA5, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(mk(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 2'b10, 8'h3C, 8'h00, 8'hA5, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(mk(1'b1, 3'b010, 3'b001, 1'b0, 1'b0, 2'b00, 8'h00, 8'h3C, 8'hA5, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(mk(1'b1, 3'b100, 3'b010, 1'b0, 1'b0, 2'b00, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(mk(1'b1, 3'b001, 3'b100, 1'b1, 1'b0, 2'b00, 8'h00, 8'h3C, 8'h3C, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1));
    vecs.push_back(mk(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h3C, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
    // Conflict: H1&H2 with C3 -> bus 0, R3 held, conflict (and illegal class) sticky.
    vecs.push_back(mk(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 2'b11, 8'h11, 8'h00, 8'h3C, 8'hA5, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
    vecs.push_back(mk(1'b1, 3'b110, 3'b001, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h3C, 8'hA5, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h3C, 8'hA5, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1));
    // Reset with T1 strobes: reset wins; bus still shows R2 combinationally.
    vecs.push_back(mk(1'b0, 3'b010, 3'b001, 1'b0, 1'b0, 2'b00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    // T2 from IDLE: capture happens, order_err set, no count.
    vecs.push_back(mk(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 2'b01, 8'h55, 8'h00, 8'h55, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(mk(1'b1, 3'b100, 3'b010, 1'b0, 1'b0, 2'b00, 8'h00, 8'h55, 8'h55, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    // Rejected load during T1, then ext_sel=00 load that is silently ignored.
    vecs.push_back(mk(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(mk(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 2'b10, 8'h77, 8'h00, 8'h00, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(mk(1'b1, 3'b010, 3'b001, 1'b0, 1'b1, 2'b10, 8'hFF, 8'h77, 8'h00, 8'h77, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    vecs.push_back(mk(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h77, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(mk(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 2'b00, 8'h99, 8'h00, 8'h00, 8'h77, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    // Swap continues after idle gaps: T2, T3 complete it.
    vecs.push_back(mk(1'b1, 3'b100, 3'b010, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    vecs.push_back(mk(1'b1, 3'b001, 3'b100, 1'b1, 1'b0, 2'b00, 8'h00, 8'h77, 8'h77, 8'h00, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1));
    // Done alone is illegal; Hi&Ci on the same register keeps it; C with no H holds.
    vecs.push_back(mk(1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h77, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
    vecs.push_back(mk(1'b1, 3'b100, 3'b100, 1'b0, 1'b0, 2'b00, 8'h00, 8'h77, 8'h77, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
    vecs.push_back(mk(1'b1, 3'b000, 3'b111, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h77, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1));

    reset = 1'b1;
    foreach (vecs[i]) begin
      v = vecs[i];
      tag = $sformatf("vec%0d", i);
      drive(v.rst_n, v.h, v.c, v.done, v.ld, v.sel, v.data);
      chk({tag, " bus"}, bus_seen, v.e_bus);
      check_outputs(tag, v.e_r1, v.e_r2, v.e_r3, v.e_conf, v.e_oerr, v.e_rej, v.e_valid, v.e_cnt);
    end

    // Reset mid-swap: T1, reset, then T2/T3 are out of order.
    drive(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00, 8'h00);
    drive(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 2'b01, 8'h42);
    drive(1'b1, 3'b010, 3'b001, 1'b0, 1'b0, 2'b00, 8'h00);
    drive(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00, 8'h00);
    check_outputs("midrst reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 3'b100, 3'b010, 1'b0, 1'b0, 2'b00, 8'h00);
    drive(1'b1, 3'b001, 3'b100, 1'b1, 1'b0, 2'b00, 8'h00);
    check_outputs("midrst T2T3", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // 256 legal swaps: counter wraps to zero, one valid per swap, no flags.
    drive(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'b00, 8'h00);
    n_valid = 0;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(8'((i + 1) % 256));
      drive(1'b1, 3'b010, 3'b001, 1'b0, 1'b0, 2'b00, 8'h00);
      if (valid) n_valid++;
      if (i % 3 == 1) idle();
      drive(1'b1, 3'b100, 3'b010, 1'b0, 1'b0, 2'b00, 8'h00);
      if (valid) n_valid++;
      drive(1'b1, 3'b001, 3'b100, 1'b1, 1'b0, 2'b00, 8'h00);
      if (valid) begin
        n_valid++;
        if (exp_q.size() > 0) chk($sformatf("wrap swap%0d cnt", i), swap_cnt, exp_q.pop_front());
      end
      if (i == 254) chk("wrap cnt at 255", swap_cnt, 8'd255);
    end
    chk("wrap valid pulses", n_valid, 256);
    chk("wrap unmatched swaps", exp_q.size(), 0);
    check_outputs("wrap end", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    idle();
    chk("wrap valid drops", valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/swap_datapath.md
# swap_datapath

Three-register datapath that consumes the control strobes of the register-swap FSM. Drive enables H1..H3 select a register onto a shared internal bus. Capture enables C1..C3 load the bus into R1..R3. The block also runs a sequence checker that counts completed swaps and flags illegal strobe combinations. An external load port presets the registers while the swap controller is idle.

## Interface
- WIDTH, 8, register and bus width in bits

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- H1, H2, H3  in  1 each  drive enables: Ri onto bus
- C1, C2, C3  in  1 each  capture enables: bus into Ri
- Done  in  1  swap-complete strobe from controller
- ext_ld  in  1  external load request
- ext_sel  in  2  load target: 01=R1, 10=R2, 11=R3, 00=none
- ext_data  in  WIDTH  external load value
- R1_q, R2_q, R3_q  out  WIDTH each  register contents
- bus  out  WIDTH  current internal bus value (combinational)
- conflict  out  1  sticky: more than one H asserted in some cycle
- order_err  out  1  sticky: strobe sequence violated
- ld_rej  out  1  one-cycle pulse: ext_ld ignored
- swap_cnt  out  8  completed swaps, modulo 256
- valid  out  1  one-cycle pulse after each completed swap

## Operation
- Reset (reset=0 at edge): R1..R3=0, conflict=0, order_err=0, ld_rej=0, swap_cnt=0, valid=0, checker=IDLE. All other inputs are ignored that cycle.
- Bus value:
  - exactly one Hi asserted: bus = Ri;
  - zero or more than one H asserted: bus = 0.
- Capture: at the edge, each Ci asserted with exactly one H asserted gives Ri <= bus.
  - Ci with no H asserted: Ri holds.
  - Ci with more than one H asserted: Ri holds.
  - Ci and Hi on the same register: Ri <= Ri, unchanged.
- Conflict: more than one H asserted at an edge sets conflict; it stays set until reset.
- External load: accepted only when all H, C and Done are 0 and ext_sel≠00; then target <= ext_data.
  - ext_ld with any strobe asserted: no load, ld_rej=1 next cycle.
  - ext_ld with ext_sel=00: no load, no reject.
- Checker FSM (states IDLE, P1, P2). Per-edge class of strobes:
  - NONE: all H, C, Done = 0.
  - T1: H2&C3 only.
  - T2: H1&C2 only.
  - T3: H3&C1&Done only.
  - anything else: ILLEGAL.
- Checker transitions:
  - IDLE: T1 -> P1.
  - P1: T2 -> P2.
  - P2: T3 -> IDLE, swap_cnt += 1 (255 wraps to 0), valid=1 next cycle.
  - NONE in any state: hold.
  - Any other class in any state: order_err set (sticky), go to IDLE.
- The checker only observes. Datapath captures proceed per the capture rules regardless of checker state.
- Done asserted outside T3: ILLEGAL, so order_err is set; swap_cnt does not change.

## Timing
- bus: combinational, zero-cycle latency from H inputs and R contents.
- R1..R3: update at the edge where the capture or load is sampled; visible the same cycle after the edge.
- conflict, order_err, ld_rej, valid, swap_cnt: registered; reflect the condition sampled at the previous edge.
- Full swap takes 3 strobe edges; valid pulses in the cycle after the T3 edge.
- Idle (NONE) cycles are permitted between T1/T2/T3 without error.
- Reset mid-swap: the checker returns to IDLE and registers clear. A subsequent T2 or T3 without a preceding T1 sets order_err.
- reset and strobes in the same edge: reset wins; no capture, no count.

## Test plan
- Ext-load R1=0xA5, R2=0x3C; drive T1, T2, T3 on consecutive edges -> R3=0x3C, R2=0xA5, R1=0x3C. swap_cnt=1, valid high exactly one cycle, order_err=0.
- H1&H2 with C3, R3=0x11 -> bus=0, R3 stays 0x11, conflict=1 next cycle and held through 5 idle cycles.
- From IDLE drive T2 with R1=0x55 -> R2=0x55 (capture still done), order_err=1, swap_cnt unchanged.
- ext_ld=1, ext_sel=10, ext_data=0xFF while H2&C3 asserted -> R2 unchanged, R3 <= R2, ld_rej pulses one cycle.
- T1, then reset=0 for one edge, then T2, T3 -> all registers 0 after reset, order_err=1, swap_cnt=0.
- 256 legal swaps -> swap_cnt returns to 0x00, valid pulsed 256 times, no error flags.
